// File: rtl/debounced_counter.sv
// Up/down counter driven by two raw push-buttons, each synchronised and debounced.
// Optional hold-to-repeat is built when DEBOUNCED_COUNTER_AUTO_REPEAT_EN is defined.
module debounced_counter #(
  parameter int WIDTH     = 8,
  parameter int DB_CYCLES = 16,
  parameter int SATURATE  = 0
`ifdef DEBOUNCED_COUNTER_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_DELAY  = 64,
  parameter int REPEAT_PERIOD = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [15:0]      DB_LAST  = 16'(DB_CYCLES - 1);
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  // Bit 0 is the up button, bit 1 the down button throughout.
  logic [1:0]  raw;
  logic [1:0]  sync1, sync2;
  logic [1:0]  level, level_q;
  logic [1:0]  event_c, event_q;
  logic [15:0] db_cnt [2];

  assign raw = {btn_down, btn_up};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_q <= '0;
      event_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      event_q <= event_c;
      // Any cycle agreeing with the accepted level restarts the stability run.
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          level[i]  <= ~level[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 16'd1;
        end
      end
    end
  end

`ifdef DEBOUNCED_COUNTER_AUTO_REPEAT_EN
  localparam logic [15:0] RPT_FIRST = 16'(REPEAT_DELAY - 1);
  localparam logic [15:0] RPT_NEXT  = 16'(REPEAT_PERIOD - 1);

  logic [15:0] rpt_cnt [2];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        rpt_cnt[i] <= '0;
      end else if (level[i] & ~level_q[i]) begin
        rpt_cnt[i] <= RPT_FIRST;
      end else if (level[i]) begin
        rpt_cnt[i] <= (rpt_cnt[i] == '0) ? RPT_NEXT : rpt_cnt[i] - 16'd1;
      end
    end
  end

  // A repeat fires only once the level has been high for at least one cycle,
  // so the press cycle itself never double-counts.
  always_comb begin
    event_c = '0;
    for (int i = 0; i < 2; i++) begin
      event_c[i] = (level[i] & ~level_q[i]) |
                   (level[i] & level_q[i] & (rpt_cnt[i] == '0));
    end
  end
`else
  assign event_c = level & ~level_q;
`endif

  logic up_ev, dn_ev;
  assign up_ev = event_q[0] & ~event_q[1];
  assign dn_ev = event_q[1] & ~event_q[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      carry <= 1'b0;
    end else if (load) begin
      count <= load_value;
      carry <= 1'b0;
    end else if (up_ev) begin
      carry <= (count == ALL_ONES);
      if (count != ALL_ONES || SATURATE == 0) count <= count + WIDTH'(1);
    end else if (dn_ev) begin
      carry <= (count == '0);
      if (count != '0 || SATURATE == 0) count <= count - WIDTH'(1);
    end else begin
      carry <= 1'b0;
    end
  end

  assign at_max = (count == ALL_ONES);
  assign at_min = (count == '0);

endmodule

// File: tb/tb_debounced_counter.sv
// Bench for debounced_counter: a wrapping and a saturating instance share stimulus
// and are compared every cycle against an arithmetic reference model.
module tb_debounced_counter;

  localparam int W  = 4;
  localparam int DB = 4;
`ifdef DEBOUNCED_COUNTER_AUTO_REPEAT_EN
  localparam int RD = 8;
  localparam int RP = 4;
  localparam int SINGLE_FINAL = 3;
`else
  localparam int SINGLE_FINAL = 1;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic btn_up = 1'b0, btn_down = 1'b0, load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic [W-1:0] count, count_s;
  logic carry, at_max, at_min, carry_s, at_max_s, at_min_s;

  debounced_counter #(.WIDTH(W), .DB_CYCLES(DB), .SATURATE(0)
`ifdef DEBOUNCED_COUNTER_AUTO_REPEAT_EN
    , .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
`endif
  ) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .load(load), .load_value(load_value),
    .count(count), .carry(carry), .at_max(at_max), .at_min(at_min)
  );

  debounced_counter #(.WIDTH(W), .DB_CYCLES(DB), .SATURATE(1)
`ifdef DEBOUNCED_COUNTER_AUTO_REPEAT_EN
    , .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
`endif
  ) dut_s (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .load(load), .load_value(load_value),
    .count(count_s), .carry(carry_s), .at_max(at_max_s), .at_min(at_min_s)
  );

  logic [13:0] obs;
  assign obs = {count, carry, at_max, at_min, count_s, carry_s, at_max_s, at_min_s};

  int errors = 0;
  int checks = 0;

  // scoreboard: reference model state and expected queue
  logic [13:0] exp_q[$];
  int   edge_n = 0;
  int   mc, mcs;
  logic m_carry, m_carry_s;
  logic [1:0] m_s1, m_s2, m_lvl;
  int   m_run [2];
  int   m_ev_at [2];
  int   m_rpt_due [2];

  // Advance one clock edge and the model with the inputs sampled at that edge.
  task automatic step();
    logic up_e, dn_e, smp, rawb;
    @(posedge clk);
    edge_n++;
    if (reset) begin
      mc = 0; mcs = 0; m_carry = 1'b0; m_carry_s = 1'b0;
      m_s1 = '0; m_s2 = '0; m_lvl = '0;
      for (int b = 0; b < 2; b++) begin
        m_run[b] = 0; m_ev_at[b] = -1; m_rpt_due[b] = -1;
      end
    end else begin
      up_e = (m_ev_at[0] == edge_n);
      dn_e = (m_ev_at[1] == edge_n);
      m_carry = 1'b0; m_carry_s = 1'b0;
      if (load) begin
        mc = int'(load_value); mcs = int'(load_value);
      end else if (up_e && !dn_e) begin
        m_carry = (mc == 15);
        mc = (mc + 1) % 16;
        if (mcs == 15) m_carry_s = 1'b1; else mcs = mcs + 1;
      end else if (dn_e && !up_e) begin
        m_carry = (mc == 0);
        mc = (mc + 15) % 16;
        if (mcs == 0) m_carry_s = 1'b1; else mcs = mcs - 1;
      end
      for (int b = 0; b < 2; b++) begin
        rawb = (b == 0) ? btn_up : btn_down;
        smp = m_s2[b]; m_s2[b] = m_s1[b]; m_s1[b] = rawb;
        if (smp == m_lvl[b]) begin
          m_run[b] = 0;
        end else begin
          m_run[b]++;
          if (m_run[b] == DB) begin
            m_lvl[b] = ~m_lvl[b];
            m_run[b] = 0;
            if (m_lvl[b]) begin
              m_ev_at[b] = edge_n + 2;
`ifdef DEBOUNCED_COUNTER_AUTO_REPEAT_EN
              m_rpt_due[b] = edge_n + 2 + RD;
`endif
            end
          end
        end
`ifdef DEBOUNCED_COUNTER_AUTO_REPEAT_EN
        if (m_lvl[b] && m_rpt_due[b] == edge_n + 2) begin
          m_ev_at[b] = edge_n + 2;
          m_rpt_due[b] = m_rpt_due[b] + RP;
        end
`endif
      end
    end
    exp_q.push_back({4'(mc), m_carry, mc == 15, mc == 0,
                     4'(mcs), m_carry_s, mcs == 15, mcs == 0});
    #1;
  endtask

  task automatic test_reset();
    logic [13:0] exp;
    reset = 1'b1; load = 1'b1; load_value = 4'd9; btn_up = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL reset_hold cyc=%0d got=%h exp=%h", edge_n, obs, exp);
      end
    end
    checks++;
    if (count !== 4'd0 || carry !== 1'b0 || at_min !== 1'b1 || at_max !== 1'b0) begin
      errors++;
      $display("FAIL reset_state count=%0d carry=%b at_min=%b at_max=%b want 0/0/1/0",
               count, carry, at_min, at_max);
    end
    reset = 1'b0; load = 1'b0; btn_up = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", edge_n, obs, exp);
      end
    end
  endtask

  task automatic test_single_press();
    logic [13:0] exp;
    int carry_seen = 0;
    btn_up = 1'b1;
    for (int k = 0; k < 34; k++) begin
      if (k == 20) btn_up = 1'b0;
      step();
      exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL single_press cyc=%0d got=%h exp=%h", edge_n, obs, exp);
      end
      if (carry) carry_seen++;
      if (k == 6 || k == 7 || k == 19) begin
        checks++;
        if (int'(count) != (k == 6 ? 0 : (k == 7 ? 1 : SINGLE_FINAL))) begin
          errors++;
          $display("FAIL single_press_latency edge=%0d got=%0d exp=%0d", k, count,
                   (k == 6 ? 0 : (k == 7 ? 1 : SINGLE_FINAL)));
        end
      end
    end
    checks++;
    if (carry_seen != 0) begin
      errors++; $display("FAIL single_press_carry got=%0d exp=0", carry_seen);
    end
  endtask

  task automatic test_bounce();
    logic [13:0] exp;
    int start = mc;
    for (int k = 0; k < 44; k++) begin
      btn_up = (k < 30) ? (((k / 2) % 2) == 0) : 1'b0;
      step();
      exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL bounce cyc=%0d got=%h exp=%h", edge_n, obs, exp);
      end
    end
    checks++;
    if (int'(count) != start) begin
      errors++; $display("FAIL bounce_hold got=%0d exp=%0d", count, start);
    end
  endtask

  task automatic test_wrap();
    logic [13:0] exp;
    int c_pulses, s_pulses;
    for (int dir = 0; dir < 2; dir++) begin
      c_pulses = 0; s_pulses = 0;
      load = 1'b1; load_value = (dir == 0) ? 4'd15 : 4'd0;
      step();
      exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL wrap_load cyc=%0d got=%h exp=%h", edge_n, obs, exp);
      end
      load = 1'b0;
      for (int k = 0; k < 20; k++) begin
        btn_up   = (dir == 0) && (k < 6);
        btn_down = (dir == 1) && (k < 6);
        step();
        exp = exp_q.pop_front(); checks++;
        if (obs !== exp) begin
          errors++; $display("FAIL wrap cyc=%0d got=%h exp=%h", edge_n, obs, exp);
        end
        if (carry) c_pulses++;
        if (carry_s) s_pulses++;
      end
      checks++;
      if (count !== ((dir == 0) ? 4'd0 : 4'd15) || count_s !== ((dir == 0) ? 4'd15 : 4'd0)) begin
        errors++;
        $display("FAIL wrap_value dir=%0d got=%0d/%0d exp=%0d/%0d", dir, count, count_s,
                 (dir == 0) ? 0 : 15, (dir == 0) ? 15 : 0);
      end
      checks++;
      if (c_pulses != 1 || s_pulses != 1) begin
        errors++;
        $display("FAIL wrap_carry dir=%0d got=%0d/%0d exp=1/1", dir, c_pulses, s_pulses);
      end
    end
  endtask

  task automatic test_coincident();
    logic [13:0] exp;
    int start = mc;
    int pulses = 0;
    logic [W-1:0] lv;
    for (int k = 0; k < 20; k++) begin
      btn_up = (k < 6); btn_down = (k < 6);
      step();
      exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL coincident cyc=%0d got=%h exp=%h", edge_n, obs, exp);
      end
      if (carry || carry_s) pulses++;
    end
    checks++;
    if (int'(count) != start || pulses != 0) begin
      errors++;
      $display("FAIL coincident_hold got=%0d carries=%0d exp=%0d carries=0", count, pulses, start);
    end
    lv = 4'((mc + 3) % 16);
    for (int k = 0; k < 22; k++) begin
      btn_up = (k < 8);
      load = (k == 7); load_value = lv;
      step();
      exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL load_vs_up cyc=%0d got=%h exp=%h", edge_n, obs, exp);
      end
      if (k == 7) begin
        checks++;
        if (count !== lv || carry !== 1'b0) begin
          errors++; $display("FAIL load_priority got=%0d carry=%b exp=%0d carry=0", count, carry, lv);
        end
      end
    end
    load = 1'b0;
  endtask

  task automatic test_reset_mid_press();
    logic [13:0] exp;
    btn_up = 1'b1;
    for (int k = 0; k < 44; k++) begin
      reset = (k == 5);
      if (k == 30) btn_up = 1'b0;
      step();
      exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL reset_mid cyc=%0d got=%h exp=%h", edge_n, obs, exp);
      end
      if (k == 5 || k == 12 || k == 13) begin
        checks++;
        if (count !== ((k == 13) ? 4'd1 : 4'd0)) begin
          errors++;
          $display("FAIL reset_mid_count edge=%0d got=%0d exp=%0d", k, count, (k == 13) ? 1 : 0);
        end
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_random();
    logic [13:0] exp;
    int hold_u = 0, hold_d = 0;
    for (int k = 0; k < 500; k++) begin
      if (hold_u == 0) begin btn_up = 1'($urandom_range(0, 1)); hold_u = $urandom_range(1, 12); end
      if (hold_d == 0) begin btn_down = 1'($urandom_range(0, 1)); hold_d = $urandom_range(1, 12); end
      hold_u--; hold_d--;
      load = ($urandom_range(0, 24) == 0);
      load_value = 4'($urandom_range(0, 15));
      reset = ($urandom_range(0, 149) == 0);
      step();
      exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", edge_n, obs, exp);
      end
    end
    reset = 1'b0; load = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    for (int k = 0; k < 14; k++) begin
      step();
      exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL random_drain cyc=%0d got=%h exp=%h", edge_n, obs, exp);
      end
    end
  endtask

`ifdef DEBOUNCED_COUNTER_AUTO_REPEAT_EN
  task automatic test_repeat();
    logic [13:0] exp;
    int want;
    reset = 1'b1; step(); void'(exp_q.pop_front()); reset = 1'b0;
    for (int k = 0; k < 56; k++) begin
      btn_up = (k < 40);
      step();
      exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin
        errors++; $display("FAIL repeat cyc=%0d got=%h exp=%h", edge_n, obs, exp);
      end
      if (k < 40) begin
        want = (k >= 7 ? 1 : 0) + (k >= 15 ? 1 + (k - 15) / 4 : 0);
        checks++;
        if (int'(count) != want) begin
          errors++; $display("FAIL repeat_schedule edge=%0d got=%0d exp=%0d", k, count, want);
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_wrap();
    test_coincident();
    test_reset_mid_press();
    test_random();
`ifdef DEBOUNCED_COUNTER_AUTO_REPEAT_EN
    test_repeat();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
